// File: rtl/prewish_mask_sequencer.sv
// rtl/prewish_mask_sequencer.sv - playlist of blink masks replayed to the mentor at a fixed dwell period
module prewish_mask_sequencer #(
  parameter int DEPTH_BITS  = 3,
  parameter int TICK_BITS   = 21,
  parameter int DWELL_TICKS = 16,
  parameter int ALIVE_BITS  = 22
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  STB_I,
  input  logic [7:0]            DAT_I,
  input  logic                  i_clear,
  input  logic                  i_run,
  output logic                  STB_O,
  output logic [7:0]            DAT_O,
  output logic [DEPTH_BITS:0]   o_count,
  output logic                  o_full,
  output logic                  o_alive
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [7:0] DWELL_C = 8'(DWELL_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DWELL} state_t;

  state_t                  state_q, state_d;
  logic                    stb_q, stb_d;
  logic [7:0]              dat_q, dat_d;
  logic [DEPTH_BITS:0]     count_q, count_d;
  logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TICK_BITS-1:0]    presc_q, presc_d;
  logic [7:0]              dwell_q, dwell_d;
  logic [ALIVE_BITS-1:0]   alive_q, alive_d;
  logic [7:0]              mem_q [DEPTH];
  logic                    wr_en;
  logic                    full;

  assign full = (count_q == DEPTH_C);

  always_comb begin
    state_d  = state_q;
    stb_d    = 1'b0;
    dat_d    = dat_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    presc_d  = presc_q;
    dwell_d  = dwell_q;
    alive_d  = alive_q + 1'b1;
    wr_en    = 1'b0;
    if (i_clear) begin
      // Clear wins over a same-cycle write and over run; DAT_O keeps its value.
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = S_IDLE;
    end else begin
      if (STB_I && !full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (i_run && count_q != '0) begin
            state_d = S_EMIT;
            stb_d   = 1'b1;
            dat_d   = mem_q[rd_ptr_q];
          end
        end
        S_EMIT: begin
          rd_ptr_d = ({1'b0, rd_ptr_q} == (count_q - 1'b1)) ? '0 : rd_ptr_q + 1'b1;
          presc_d  = '0;
          dwell_d  = '0;
          state_d  = S_DWELL;
        end
        S_DWELL: begin
          if (!i_run) begin
            state_d = S_IDLE;
          end else if (dwell_q == DWELL_C) begin
            // Decision cycle: reissue or fall back to idle.
            if (count_q != '0) begin
              state_d = S_EMIT;
              stb_d   = 1'b1;
              dat_d   = mem_q[rd_ptr_q];
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            if (&presc_q) dwell_d = dwell_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= S_IDLE;
      stb_q    <= 1'b0;
      dat_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      presc_q  <= '0;
      dwell_q  <= '0;
      alive_q  <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      dat_q    <= dat_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      presc_q  <= presc_d;
      dwell_q  <= dwell_d;
      alive_q  <= alive_d;
    end
  end

  // Table contents are not reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_I && wr_en) mem_q[wr_ptr_q] <= DAT_I;
  end

  assign STB_O   = stb_q;
  assign DAT_O   = dat_q;
  assign o_count = count_q;
  assign o_full  = full;
  assign o_alive = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish_mask_sequencer.sv
// tb/tb_prewish_mask_sequencer.sv - randomized self-checking bench for prewish_mask_sequencer
module tb_prewish_mask_sequencer;

  localparam int DB = 3;
  localparam int TB = 2;
  localparam int DT = 3;
  localparam int AB = 4;
  localparam int P  = (DT << TB) + 2;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b1;
  logic          STB_I = 1'b0;
  logic [7:0]    DAT_I = 8'h00;
  logic          i_clear = 1'b0;
  logic          i_run = 1'b0;
  logic          STB_O;
  logic [7:0]    DAT_O;
  logic [DB:0]   o_count;
  logic          o_full;
  logic          o_alive;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic prev_stb = 1'b0;
  int   ev_cyc[$];
  logic [7:0] ev_dat[$];

  prewish_mask_sequencer #(.DEPTH_BITS(DB), .TICK_BITS(TB), .DWELL_TICKS(DT), .ALIVE_BITS(AB)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .DAT_I(DAT_I),
    .i_clear(i_clear), .i_run(i_run), .STB_O(STB_O), .DAT_O(DAT_O),
    .o_count(o_count), .o_full(o_full), .o_alive(o_alive)
  );

  always #5 CLK_I = ~CLK_I;

  // Strobe recorder: logs every pulse and checks no pulse lasts two cycles.
  always @(negedge CLK_I) begin
    cyc = cyc + 1;
    if (STB_O === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_dat.push_back(DAT_O);
      total = total + 1;
      if (prev_stb === 1'b1) begin
        bad = bad + 1;
        $display("FAIL stb_width at cycle %0d: strobe high two cycles in a row", cyc);
      end
    end
    prev_stb = STB_O;
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    RST_I = 1'b1; i_run = 1'b0; i_clear = 1'b0; STB_I = 1'b0;
    repeat (4) tick();
    RST_I = 1'b0;
    ev_cyc.delete();
    ev_dat.delete();
  endtask

  task automatic write(input logic [7:0] d);
    STB_I = 1'b1; DAT_I = d;
    tick();
    STB_I = 1'b0;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k = 0;
    while (ev_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (ev_cyc.size() < n) begin
      bad++;
      $display("FAIL wait_events got=%0d want=%0d", ev_cyc.size(), n);
    end
  endtask

  // Compare recorded strobes against the playlist rotation starting at entry start.
  task automatic check_seq(input string nm, input logic [7:0] tab[$], input int start,
                           input int n, input int c0);
    for (int i = 0; i < n && i < ev_cyc.size(); i++) begin
      logic [7:0] exp_d;
      int exp_c;
      exp_d = tab[(start + i) % tab.size()];
      exp_c = c0 + i * P;
      total++;
      if (ev_dat[i] !== exp_d) begin
        bad++;
        $display("FAIL %s_dat[%0d] got=%02h want=%02h", nm, i, ev_dat[i], exp_d);
      end
      total++;
      if (ev_cyc[i] !== exp_c) begin
        bad++;
        $display("FAIL %s_cyc[%0d] got=%0d want=%0d", nm, i, ev_cyc[i], exp_c);
      end
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b1; i_run = 1'b1;
    repeat (4) tick();
    total++;
    if ({STB_O, DAT_O, o_count, o_full, o_alive} !== {1'b0, 8'h00, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals got stb=%b dat=%02h cnt=%0d full=%b alive=%b want all zero",
               STB_O, DAT_O, o_count, o_full, o_alive);
    end
    RST_I = 1'b0;
    ev_cyc.delete(); ev_dat.delete();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 5 || k == 12 || k == 40) begin
        total++;
        if (o_alive !== ((k % 16) >= 8)) begin
          bad++;
          $display("FAIL alive_k%0d got=%b want=%b", k, o_alive, ((k % 16) >= 8));
        end
      end
    end
    total++;
    if (ev_cyc.size() != 0 || o_count !== 4'd0 || DAT_O !== 8'h00) begin
      bad++;
      $display("FAIL idle_empty got strobes=%0d cnt=%0d dat=%02h want 0 0 00",
               ev_cyc.size(), o_count, DAT_O);
    end
    i_run = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] tab[$];
    int c0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      write(8'(i));
      if (i <= 8) tab.push_back(8'(i));
    end
    total++;
    if (o_count !== 4'd8 || o_full !== 1'b1) begin
      bad++;
      $display("FAIL fill_count got cnt=%0d full=%b want cnt=8 full=1", o_count, o_full);
    end
    i_run = 1'b1; c0 = cyc + 2;
    wait_ev(9, 9 * P + 10);
    check_seq("fill", tab, 0, 9, c0);
    i_run = 1'b0;
  endtask

  task automatic test_cadence();
    logic [7:0] tab[$];
    int c0;
    do_reset();
    tab = '{8'hA5, 8'h3C};
    write(8'hA5); write(8'h3C);
    i_run = 1'b1; c0 = cyc + 2;
    wait_ev(3, 3 * P + 10);
    check_seq("cadence", tab, 0, 3, c0);
    i_run = 1'b0;
  endtask

  task automatic test_pause_resume();
    logic [7:0] tab[$];
    int c0;
    do_reset();
    tab = '{8'hA5, 8'h3C};
    write(8'hA5); write(8'h3C);
    i_run = 1'b1; c0 = cyc + 2;
    wait_ev(1, P);
    repeat (5) tick();
    i_run = 1'b0;
    repeat (3 * P) tick();
    total++;
    if (ev_cyc.size() != 1 || DAT_O !== 8'hA5) begin
      bad++;
      $display("FAIL pause_hold got strobes=%0d dat=%02h want 1 a5", ev_cyc.size(), DAT_O);
    end
    check_seq("pause_first", tab, 0, 1, c0);
    ev_cyc.delete(); ev_dat.delete();
    i_run = 1'b1; c0 = cyc + 2;
    wait_ev(2, 2 * P + 10);
    check_seq("resume", tab, 1, 2, c0);
    i_run = 1'b0;
  endtask

  task automatic test_clear_vs_write();
    logic [7:0] tab[$];
    int c0;
    do_reset();
    repeat (3) write(8'($urandom_range(0, 255)));
    i_clear = 1'b1; STB_I = 1'b1; DAT_I = 8'h77;
    tick();
    i_clear = 1'b0; STB_I = 1'b0;
    total++;
    if (o_count !== 4'd0 || STB_O !== 1'b0 || o_full !== 1'b0) begin
      bad++;
      $display("FAIL clear_wins got cnt=%0d stb=%b full=%b want 0 0 0", o_count, STB_O, o_full);
    end
    write(8'h11);
    total++;
    if (o_count !== 4'd1) begin
      bad++;
      $display("FAIL clear_then_write got cnt=%0d want 1", o_count);
    end
    tab = '{8'h11};
    i_run = 1'b1; c0 = cyc + 2;
    wait_ev(3, 3 * P + 10);
    check_seq("single", tab, 0, 3, c0);
    i_run = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    write(8'h5A); write(8'hC3);
    i_run = 1'b1;
    while (STB_O !== 1'b1 && k < 2 * P) begin
      tick();
      k++;
    end
    total++;
    if (STB_O !== 1'b1) begin
      bad++;
      $display("FAIL reach_emit got stb=%b want 1", STB_O);
    end
    RST_I = 1'b1;
    tick();
    total++;
    if (STB_O !== 1'b0 || o_count !== 4'd0 || DAT_O !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid got stb=%b cnt=%0d dat=%02h want 0 0 00", STB_O, o_count, DAT_O);
    end
    RST_I = 1'b0;
    ev_cyc.delete(); ev_dat.delete();
    repeat (3 * P) tick();
    total++;
    if (ev_cyc.size() != 0) begin
      bad++;
      $display("FAIL post_reset_quiet got strobes=%0d want 0", ev_cyc.size());
    end
    i_run = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] tab[$];
      int n, c0;
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        tab.push_back(8'($urandom_range(0, 255)));
        write(tab[i]);
      end
      total++;
      if (o_count !== 4'(n) || o_full !== (n == 8)) begin
        bad++;
        $display("FAIL rand_count it%0d got cnt=%0d full=%b want %0d %b", it, o_count, o_full, n, (n == 8));
      end
      i_run = 1'b1; c0 = cyc + 2;
      wait_ev(n + 2, (n + 2) * P + 10);
      check_seq("rand", tab, 0, n + 2, c0);
      i_run = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_cadence();
    test_pause_resume();
    test_clear_vs_write();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prewish_mask_sequencer.md
Name: prewish_mask_sequencer

Overview:
- Stores a short playlist of 8-bit blink masks and replays them one at a time to prewish_mentor, so the LED pattern changes automatically.
- Sits between the button/DIP mask loader in prewish_controller and the mentor.
- Upstream, the loader writes entries with a one-cycle strobe.
- Downstream, the sequencer issues one-cycle STB_O/DAT_O pulses to the mentor at a fixed dwell period while run is asserted.

Parameters:
- DEPTH_BITS, 3, log2 of table depth; DEPTH = 2**DEPTH_BITS entries (8).
- TICK_BITS, 21, prescaler width; one dwell tick = 2**TICK_BITS clocks.
- DWELL_TICKS, 16, ticks each mask is held before the next is issued (1..255).
- ALIVE_BITS, 22, width of the free-running alive counter; its MSB drives o_alive.

Ports:
- CLK_I  in  1  system clock (syscon CLK_O).
- RST_I  in  1  synchronous, active-high reset.
- STB_I  in  1  one-cycle write strobe from the mask loader.
- DAT_I  in  8  mask to append, sampled when STB_I=1.
- i_clear  in  1  synchronous playlist clear, level-sampled.
- i_run  in  1  1 = sequence; 0 = hold the last issued mask.
- STB_O  out  1  one-cycle strobe to mentor STB_I.
- DAT_O  out  8  mask to mentor DAT_I; valid while STB_O=1, held afterwards.
- o_count  out  DEPTH_BITS+1  number of stored entries (0..DEPTH).
- o_full  out  1  o_count == DEPTH.
- o_alive  out  1  MSB of the alive counter.

Behaviour:
- Clock and reset: one clock, CLK_I. Reset is synchronous and active-high on RST_I.
- Reset values: STB_O=0, DAT_O=0, o_count=0, o_full=0, o_alive=0, wr_ptr=0, rd_ptr=0, state=IDLE, prescaler=0, dwell counter=0. Table contents are don't-care.
- Writes (any state): STB_I=1 with count<DEPTH stores DAT_I at wr_ptr, then wr_ptr+1 and count+1, visible the next cycle. STB_I while full is silently dropped and nothing changes.
- Clear: i_clear=1 sets count=0, wr_ptr=0, rd_ptr=0, state=IDLE and STB_O=0 next cycle. DAT_O is held. Clear has priority over a simultaneous STB_I (the write is lost) and over run.
- State IDLE: if i_run=1 and count>0, go to EMIT. Otherwise stay.
- State EMIT (one cycle):
  - STB_O=1, DAT_O=table[rd_ptr].
  - rd_ptr <= (rd_ptr == count-1) ? 0 : rd_ptr+1, where wrap compares against the current count.
  - Prescaler and dwell counter cleared; go to DWELL.
- State DWELL:
  - STB_O=0. Prescaler counts every clock; on prescaler wrap, dwell counter +1.
  - When the dwell counter reaches DWELL_TICKS: if i_run=1 and count>0, go to EMIT, else go to IDLE.
  - i_run=0 at any DWELL cycle goes to IDLE next cycle. rd_ptr is retained, so resuming continues from the next entry.
- Latency:
  - i_run sampled 1 in IDLE gives STB_O high on the following cycle.
  - While running, consecutive STB_O rising edges are P = (DWELL_TICKS << TICK_BITS) + 2 clocks apart: 1 EMIT cycle, DWELL_TICKS·2^TICK_BITS counting cycles, and 1 decision cycle.
- count==1: the same mask is re-issued every period; the mentor reload is harmless.
- Append while running: the new entry joins the rotation from the next wrap decision onward.
- STB_O is never high in two consecutive cycles.
- o_alive: free-running counter, unaffected by clear. It resets to 0 on RST_I.
- Reset mid-DWELL or mid-EMIT: everything returns to reset values on the next edge, and STB_O drops that cycle.

Test Plan:
(sim params TICK_BITS=2, DWELL_TICKS=3, so P=14)
- Reset then idle: RST_I for 4 cycles, i_run=1 with an empty table -> STB_O never asserts; o_count=0, DAT_O=0.
- Fill/overflow: write 0x01,0x02,…,0x09 on 9 consecutive cycles -> o_count=8, o_full=1; 0x09 dropped. Cycling run then emits 0x01..0x08 in order and wraps back to 0x01.
- Run cadence: table {0xA5,0x3C}, raise i_run -> STB_O on the next cycle with DAT_O=0xA5. STB_O rises again 14 clocks later with 0x3C, then 14 clocks later with 0xA5. Each pulse is exactly 1 cycle.
- Pause/resume: drop i_run mid-DWELL after 0xA5 -> IDLE, no strobes, DAT_O holds 0xA5. Raise i_run -> next emit is 0x3C.
- Clear vs write: i_clear and STB_I(0x77) in the same cycle -> o_count=0, 0x77 not stored, STB_O=0. Then write 0x11 -> o_count=1; with i_run=1, 0x11 repeats every 14 clocks.
- Reset mid-operation: assert RST_I during EMIT -> STB_O=0 the next cycle, o_count=0. No strobes after release until new writes and run.
